// File: rtl/uifdma_fbuf_sched.sv
// uifdma_fbuf_sched: frame-buffer scheduler in front of the uiFDMA command ports.
// Converts per-line write/read requests into FDMA transactions. Line addresses are
// generated inside a ring of BUF_NUM frame buffers, and the writer steps around the
// buffer the reader is currently displaying.
// Optional feature: define FDMA_OVF_CNT_EN to add saturating lost-request counters
// (wr_ovf_cnt / rd_ovf_cnt). Without it those ports and counters do not exist.
module uifdma_fbuf_sched #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 128,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h1000_0000,
    parameter int                    H_WORDS     = 240,
    parameter int                    V_LINES     = 1080,
    parameter int                    BUF_NUM     = 3,
    parameter logic [ADDR_WIDTH-1:0] FRAME_BYTES = 32'h0080_0000
) (
    input  logic                  M_AXI_ACLK,
    input  logic                  M_AXI_ARESETN,
    input  logic                  wr_fs,
    input  logic                  wr_line_req,
    input  logic                  rd_fs,
    input  logic                  rd_line_req,
    output logic [ADDR_WIDTH-1:0] fdma_waddr,
    output logic                  fdma_wareq,
    output logic [15:0]           fdma_wsize,
    input  logic                  fdma_wbusy,
    output logic [ADDR_WIDTH-1:0] fdma_raddr,
    output logic                  fdma_rareq,
    output logic [15:0]           fdma_rsize,
    input  logic                  fdma_rbusy,
    output logic [1:0]            wr_buf_idx,
    output logic [1:0]            rd_buf_idx,
`ifdef FDMA_OVF_CNT_EN
    output logic [15:0]           wr_ovf_cnt,
    output logic [15:0]           rd_ovf_cnt,
`endif
    output logic                  wr_ovf,
    output logic                  rd_ovf
);

    localparam logic [ADDR_WIDTH-1:0] LINE_BYTES = ADDR_WIDTH'(H_WORDS * (DATA_WIDTH / 8));
    localparam logic [11:0]           LAST_LINE  = 12'(V_LINES - 1);

    typedef enum logic [1:0] {W_IDLE, W_REQ, W_BUSY} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_REQ, R_BUSY} r_state_t;

    w_state_t    w_state;
    r_state_t    r_state;
    logic [11:0] wr_line;
    logic [11:0] rd_line;
    logic [1:0]  last_done;
    logic        wr_pend;
    logic        rd_pend;
    logic        wr_fs_pend;
    logic        rd_fs_pend;

    logic        wr_pend_clr;
    logic        rd_pend_clr;
    logic        wr_ovf_evt;
    logic        rd_ovf_evt;
    logic        wr_frame_end;
    logic [1:0]  last_done_fwd;
    logic        wr_fs_now;
    logic        rd_fs_now;
    logic [1:0]  rd_buf_eff;

    // Line address inside the buffer ring, all arithmetic in ADDR_WIDTH bits.
    function automatic logic [ADDR_WIDTH-1:0] calc_addr(input logic [1:0] b, input logic [11:0] l);
        return BASE_ADDR + (ADDR_WIDTH'(b) * FRAME_BYTES) + (ADDR_WIDTH'(l) * LINE_BYTES);
    endfunction

    // Next buffer for the writer; with three or more buffers it never lands on the reader's buffer.
    function automatic logic [1:0] next_wbuf(input logic [1:0] wb, input logic [1:0] rb);
        int n;
        n = (int'(wb) + 1) % BUF_NUM;
        if ((BUF_NUM >= 3) && (n == int'(rb))) begin
            n = (int'(wb) + 2) % BUF_NUM;
        end
        return 2'(n);
    endfunction

    assign fdma_wsize    = 16'(H_WORDS);
    assign fdma_rsize    = 16'(H_WORDS);

    assign wr_pend_clr   = (w_state == W_REQ) && fdma_wbusy;
    assign rd_pend_clr   = (r_state == R_REQ) && fdma_rbusy;
    assign wr_ovf_evt    = wr_line_req && wr_pend && !wr_pend_clr;
    assign rd_ovf_evt    = rd_line_req && rd_pend && !rd_pend_clr;
    assign wr_frame_end  = (w_state == W_BUSY) && !fdma_wbusy && (wr_line == LAST_LINE);
    assign last_done_fwd = wr_frame_end ? wr_buf_idx : last_done;
    assign wr_fs_now     = wr_fs || wr_fs_pend;
    assign rd_fs_now     = rd_fs || rd_fs_pend;
    assign rd_buf_eff    = rd_fs_now ? last_done_fwd : rd_buf_idx;

    // Write side: request bookkeeping, FSM, line counter and buffer advance.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            w_state    <= W_IDLE;
            wr_line    <= '0;
            wr_buf_idx <= '0;
            last_done  <= '0;
            wr_pend    <= 1'b0;
            wr_fs_pend <= 1'b0;
            wr_ovf     <= 1'b0;
            fdma_wareq <= 1'b0;
            fdma_waddr <= BASE_ADDR;
        end else begin
            if (wr_line_req) begin
                wr_pend <= 1'b1;
            end else if (wr_pend_clr) begin
                wr_pend <= 1'b0;
            end
            if (wr_ovf_evt) begin
                wr_ovf <= 1'b1;
            end
            if (wr_fs) begin
                wr_fs_pend <= 1'b1;
            end
            case (w_state)
                W_IDLE: begin
                    if (wr_fs_now) begin
                        wr_line    <= '0;
                        wr_fs_pend <= 1'b0;
                    end
                    if (wr_pend || wr_line_req) begin
                        fdma_waddr <= calc_addr(wr_buf_idx, wr_fs_now ? 12'd0 : wr_line);
                        fdma_wareq <= 1'b1;
                        w_state    <= W_REQ;
                    end
                end
                W_REQ: begin
                    if (fdma_wbusy) begin
                        fdma_wareq <= 1'b0;
                        w_state    <= W_BUSY;
                    end
                end
                W_BUSY: begin
                    if (!fdma_wbusy) begin
                        w_state <= W_IDLE;
                        if (wr_line == LAST_LINE) begin
                            wr_line    <= '0;
                            last_done  <= wr_buf_idx;
                            wr_buf_idx <= next_wbuf(wr_buf_idx, rd_buf_idx);
                        end else begin
                            wr_line <= wr_line + 12'd1;
                        end
                    end
                end
                default: begin
                    w_state    <= W_IDLE;
                    fdma_wareq <= 1'b0;
                end
            endcase
        end
    end

    // Read side: same handshake; frame start picks up the most recently completed buffer.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            r_state    <= R_IDLE;
            rd_line    <= '0;
            rd_buf_idx <= '0;
            rd_pend    <= 1'b0;
            rd_fs_pend <= 1'b0;
            rd_ovf     <= 1'b0;
            fdma_rareq <= 1'b0;
            fdma_raddr <= BASE_ADDR;
        end else begin
            if (rd_line_req) begin
                rd_pend <= 1'b1;
            end else if (rd_pend_clr) begin
                rd_pend <= 1'b0;
            end
            if (rd_ovf_evt) begin
                rd_ovf <= 1'b1;
            end
            if (rd_fs) begin
                rd_fs_pend <= 1'b1;
            end
            case (r_state)
                R_IDLE: begin
                    if (rd_fs_now) begin
                        rd_line    <= '0;
                        rd_buf_idx <= last_done_fwd;
                        rd_fs_pend <= 1'b0;
                    end
                    if (rd_pend || rd_line_req) begin
                        fdma_raddr <= calc_addr(rd_buf_eff, rd_fs_now ? 12'd0 : rd_line);
                        fdma_rareq <= 1'b1;
                        r_state    <= R_REQ;
                    end
                end
                R_REQ: begin
                    if (fdma_rbusy) begin
                        fdma_rareq <= 1'b0;
                        r_state    <= R_BUSY;
                    end
                end
                R_BUSY: begin
                    if (!fdma_rbusy) begin
                        r_state <= R_IDLE;
                        if (rd_line == LAST_LINE) begin
                            rd_line <= '0;
                        end else begin
                            rd_line <= rd_line + 12'd1;
                        end
                    end
                end
                default: begin
                    r_state    <= R_IDLE;
                    fdma_rareq <= 1'b0;
                end
            endcase
        end
    end

`ifdef FDMA_OVF_CNT_EN
    // Saturating counts of lost line requests on each side.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            wr_ovf_cnt <= '0;
            rd_ovf_cnt <= '0;
        end else begin
            if (wr_ovf_evt && (wr_ovf_cnt != 16'hFFFF)) begin
                wr_ovf_cnt <= wr_ovf_cnt + 16'd1;
            end
            if (rd_ovf_evt && (rd_ovf_cnt != 16'hFFFF)) begin
                rd_ovf_cnt <= rd_ovf_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_uifdma_fbuf_sched.sv
// tb_uifdma_fbuf_sched: directed, table-driven bench for uifdma_fbuf_sched with
// hand-written sequences for frame ends, buffer skipping, overflow and async reset.
module tb_uifdma_fbuf_sched;

    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam logic [31:0] FRAME = 32'h0080_0000;
    localparam logic [31:0] LINEB = 32'd3840;
    localparam int          LINES = 1080;

    logic        M_AXI_ACLK = 1'b0;
    logic        M_AXI_ARESETN = 1'b0;
    logic        wr_fs = 1'b0;
    logic        wr_line_req = 1'b0;
    logic        rd_fs = 1'b0;
    logic        rd_line_req = 1'b0;
    logic        fdma_wbusy = 1'b0;
    logic        fdma_rbusy = 1'b0;
    logic [31:0] fdma_waddr;
    logic        fdma_wareq;
    logic [15:0] fdma_wsize;
    logic [31:0] fdma_raddr;
    logic        fdma_rareq;
    logic [15:0] fdma_rsize;
    logic [1:0]  wr_buf_idx;
    logic [1:0]  rd_buf_idx;
    logic        wr_ovf;
    logic        rd_ovf;
`ifdef FDMA_OVF_CNT_EN
    logic [15:0] wr_ovf_cnt;
    logic [15:0] rd_ovf_cnt;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic        is_rd;
        logic        fs;
        logic [31:0] exp_addr;
        logic [1:0]  exp_wbuf;
        logic [1:0]  exp_rbuf;
    } vec_t;

    vec_t vecs [8];

    uifdma_fbuf_sched dut (
        .M_AXI_ACLK   (M_AXI_ACLK),
        .M_AXI_ARESETN(M_AXI_ARESETN),
        .wr_fs        (wr_fs),
        .wr_line_req  (wr_line_req),
        .rd_fs        (rd_fs),
        .rd_line_req  (rd_line_req),
        .fdma_waddr   (fdma_waddr),
        .fdma_wareq   (fdma_wareq),
        .fdma_wsize   (fdma_wsize),
        .fdma_wbusy   (fdma_wbusy),
        .fdma_raddr   (fdma_raddr),
        .fdma_rareq   (fdma_rareq),
        .fdma_rsize   (fdma_rsize),
        .fdma_rbusy   (fdma_rbusy),
        .wr_buf_idx   (wr_buf_idx),
        .rd_buf_idx   (rd_buf_idx),
`ifdef FDMA_OVF_CNT_EN
        .wr_ovf_cnt   (wr_ovf_cnt),
        .rd_ovf_cnt   (rd_ovf_cnt),
`endif
        .wr_ovf       (wr_ovf),
        .rd_ovf       (rd_ovf)
    );

    // Free-running 100 MHz clock.
    always #5 M_AXI_ACLK = ~M_AXI_ACLK;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // One line transaction with a modelled FDMA busy window of busy_cycles clocks.
    task automatic runLine(input bit is_rd, input int busy_cycles, input bit rdfs_at_end,
                           input logic [31:0] exp_addr, input string name);
        if (is_rd) rd_line_req = 1'b1; else wr_line_req = 1'b1;
        @(posedge M_AXI_ACLK); #1;
        rd_line_req = 1'b0;
        wr_line_req = 1'b0;
        checkOutput({name, " areq"}, is_rd ? 32'(fdma_rareq) : 32'(fdma_wareq), 32'd1);
        checkOutput({name, " addr"}, is_rd ? fdma_raddr : fdma_waddr, exp_addr);
        if (is_rd) fdma_rbusy = 1'b1; else fdma_wbusy = 1'b1;
        @(posedge M_AXI_ACLK); #1;
        checkOutput({name, " areq drop"}, is_rd ? 32'(fdma_rareq) : 32'(fdma_wareq), 32'd0);
        for (int k = 1; k < busy_cycles; k++) begin
            @(posedge M_AXI_ACLK); #1;
        end
        if (is_rd) fdma_rbusy = 1'b0; else fdma_wbusy = 1'b0;
        if (rdfs_at_end) rd_fs = 1'b1;
        @(posedge M_AXI_ACLK); #1;
        rd_fs = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        if (v.fs) begin
            if (v.is_rd) rd_fs = 1'b1; else wr_fs = 1'b1;
            @(posedge M_AXI_ACLK); #1;
            rd_fs = 1'b0;
            wr_fs = 1'b0;
        end
        runLine(v.is_rd, 2, 1'b0, v.exp_addr, $sformatf("vec%0d", idx));
        checkOutput($sformatf("vec%0d wr_buf_idx", idx), 32'(wr_buf_idx), 32'(v.exp_wbuf));
        checkOutput($sformatf("vec%0d rd_buf_idx", idx), 32'(rd_buf_idx), 32'(v.exp_rbuf));
    endtask

    task automatic writeFrame(input int b, input bit rdfs_at_end);
        for (int l = 0; l < LINES; l++) begin
            runLine(1'b0, 5, rdfs_at_end && (l == LINES - 1),
                    BASE + 32'(b) * FRAME + 32'(l) * LINEB, $sformatf("wframe%0d line%0d", b, l));
        end
    endtask

    task automatic pulseRdFs();
        rd_fs = 1'b1;
        @(posedge M_AXI_ACLK); #1;
        rd_fs = 1'b0;
    endtask

    initial begin
        vecs[0] = '{is_rd: 1'b0, fs: 1'b0, exp_addr: 32'h1000_0000, exp_wbuf: 2'd0, exp_rbuf: 2'd0};
        vecs[1] = '{is_rd: 1'b0, fs: 1'b0, exp_addr: 32'h1000_0F00, exp_wbuf: 2'd0, exp_rbuf: 2'd0};
        vecs[2] = '{is_rd: 1'b0, fs: 1'b0, exp_addr: 32'h1000_1E00, exp_wbuf: 2'd0, exp_rbuf: 2'd0};
        vecs[3] = '{is_rd: 1'b0, fs: 1'b1, exp_addr: 32'h1000_0000, exp_wbuf: 2'd0, exp_rbuf: 2'd0};
        vecs[4] = '{is_rd: 1'b1, fs: 1'b0, exp_addr: 32'h1000_0000, exp_wbuf: 2'd0, exp_rbuf: 2'd0};
        vecs[5] = '{is_rd: 1'b1, fs: 1'b0, exp_addr: 32'h1000_0F00, exp_wbuf: 2'd0, exp_rbuf: 2'd0};
        vecs[6] = '{is_rd: 1'b1, fs: 1'b1, exp_addr: 32'h1000_0000, exp_wbuf: 2'd0, exp_rbuf: 2'd0};
        vecs[7] = '{is_rd: 1'b0, fs: 1'b0, exp_addr: 32'h1000_0F00, exp_wbuf: 2'd0, exp_rbuf: 2'd0};

        // Reset values while reset is held.
        repeat (3) @(posedge M_AXI_ACLK);
        #1;
        checkOutput("rst wareq", 32'(fdma_wareq), 32'd0);
        checkOutput("rst rareq", 32'(fdma_rareq), 32'd0);
        checkOutput("rst waddr", fdma_waddr, BASE);
        checkOutput("rst raddr", fdma_raddr, BASE);
        checkOutput("rst wsize", 32'(fdma_wsize), 32'd240);
        checkOutput("rst rsize", 32'(fdma_rsize), 32'd240);
        checkOutput("rst wr_buf_idx", 32'(wr_buf_idx), 32'd0);
        checkOutput("rst rd_buf_idx", 32'(rd_buf_idx), 32'd0);
        checkOutput("rst wr_ovf", 32'(wr_ovf), 32'd0);
        checkOutput("rst rd_ovf", 32'(rd_ovf), 32'd0);
        M_AXI_ARESETN = 1'b1;
        @(posedge M_AXI_ACLK); #1;

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Restart both sides at line 0 before the full frames.
        wr_fs = 1'b1;
        rd_fs = 1'b1;
        @(posedge M_AXI_ACLK); #1;
        wr_fs = 1'b0;
        rd_fs = 1'b0;

        $display("[TB] full frame into buffer 0");
        writeFrame(0, 1'b0);
        checkOutput("frame0 last waddr", fdma_waddr, 32'h103F_3900);
        checkOutput("frame0 wr_buf_idx", 32'(wr_buf_idx), 32'd1);
        pulseRdFs();
        checkOutput("frame0 rd_buf_idx", 32'(rd_buf_idx), 32'd0);

        writeFrame(1, 1'b0);
        checkOutput("frame1 wr_buf_idx", 32'(wr_buf_idx), 32'd2);
        pulseRdFs();
        checkOutput("frame1 rd_buf_idx", 32'(rd_buf_idx), 32'd1);

        writeFrame(2, 1'b0);
        checkOutput("frame2 wr_buf_idx", 32'(wr_buf_idx), 32'd0);

        $display("[TB] writer skips buffer held by reader");
        writeFrame(0, 1'b0);
        checkOutput("skip wr_buf_idx", 32'(wr_buf_idx), 32'd2);
        checkOutput("skip rd_buf_idx", 32'(rd_buf_idx), 32'd1);

        $display("[TB] rd_fs coincident with write frame end");
        writeFrame(2, 1'b1);
        checkOutput("fwd rd_buf_idx", 32'(rd_buf_idx), 32'd2);
        checkOutput("fwd wr_buf_idx", 32'(wr_buf_idx), 32'd0);

        // Full read frame from buffer 2 then wrap to line 0 in the same buffer.
        for (int l = 0; l < LINES; l++) begin
            runLine(1'b1, 1, 1'b0, 32'h1100_0000 + 32'(l) * LINEB, $sformatf("rframe line%0d", l));
        end
        runLine(1'b1, 1, 1'b0, 32'h1100_0000, "rd wrap");
        checkOutput("rd wrap rd_buf_idx", 32'(rd_buf_idx), 32'd2);

        // Simultaneous write and read requests.
        wr_line_req = 1'b1;
        rd_line_req = 1'b1;
        @(posedge M_AXI_ACLK); #1;
        wr_line_req = 1'b0;
        rd_line_req = 1'b0;
        checkOutput("sim wareq", 32'(fdma_wareq), 32'd1);
        checkOutput("sim rareq", 32'(fdma_rareq), 32'd1);
        checkOutput("sim waddr", fdma_waddr, 32'h1000_0000);
        checkOutput("sim raddr", fdma_raddr, 32'h1100_0F00);
        fdma_wbusy = 1'b1;
        fdma_rbusy = 1'b1;
        @(posedge M_AXI_ACLK); #1;
        fdma_wbusy = 1'b0;
        fdma_rbusy = 1'b0;
        @(posedge M_AXI_ACLK); #1;

        $display("[TB] lost write requests with busy stuck high");
        wr_line_req = 1'b1;
        @(posedge M_AXI_ACLK); #1;
        wr_line_req = 1'b0;
        checkOutput("ovf wareq", 32'(fdma_wareq), 32'd1);
        checkOutput("ovf waddr", fdma_waddr, 32'h1000_0F00);
        fdma_wbusy = 1'b1;
        @(posedge M_AXI_ACLK); #1;
        wr_line_req = 1'b1;
        @(posedge M_AXI_ACLK); #1;
        wr_line_req = 1'b0;
        checkOutput("ovf first pending", 32'(wr_ovf), 32'd0);
        @(posedge M_AXI_ACLK); #1;
        wr_line_req = 1'b1;
        @(posedge M_AXI_ACLK); #1;
        wr_line_req = 1'b0;
        checkOutput("ovf wr_ovf", 32'(wr_ovf), 32'd1);
        checkOutput("ovf rd_ovf", 32'(rd_ovf), 32'd0);
`ifdef FDMA_OVF_CNT_EN
        checkOutput("ovf wr_ovf_cnt", 32'(wr_ovf_cnt), 32'd1);
        checkOutput("ovf rd_ovf_cnt", 32'(rd_ovf_cnt), 32'd0);
`endif
        @(posedge M_AXI_ACLK); #1;
        checkOutput("ovf sticky", 32'(wr_ovf), 32'd1);

        $display("[TB] async reset during busy");
        M_AXI_ARESETN = 1'b0;
        #1;
        checkOutput("arst wareq", 32'(fdma_wareq), 32'd0);
        checkOutput("arst waddr", fdma_waddr, BASE);
        checkOutput("arst raddr", fdma_raddr, BASE);
        checkOutput("arst wr_ovf", 32'(wr_ovf), 32'd0);
        checkOutput("arst rd_buf_idx", 32'(rd_buf_idx), 32'd0);
`ifdef FDMA_OVF_CNT_EN
        checkOutput("arst wr_ovf_cnt", 32'(wr_ovf_cnt), 32'd0);
`endif
        fdma_wbusy = 1'b0;
        @(posedge M_AXI_ACLK); #3;
        M_AXI_ARESETN = 1'b1;
        @(posedge M_AXI_ACLK); #1;
        runLine(1'b0, 5, 1'b0, BASE, "post-reset");
        checkOutput("post-reset wr_buf_idx", 32'(wr_buf_idx), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
